// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU arbiter: ALU op codes,
//               arbiter FSM state encoding, requester-count ceiling and an
//               illegal-op helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int MAX_REQ = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Op codes 3'b110 and 3'b111 have no ALU function and are flagged as errors.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search for an active
//               request starts at index ptr and wraps around.
// Ports       : req       - request vector (one bit per requester)
//               ptr       - highest-priority index for this cycle
//               grant     - one-hot grant
//               idx       - encoded index of the granted requester
//               any_grant - at least one request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_grant
);

    always_comb begin
        int w_pos;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        w_pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                idx          = ID_W'(w_pos);
                any_grant    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one 32-bit combinational ALU between NUM_REQ
//               requesters. Round-robin grant, operand capture, one EXEC
//               cycle on the ALU, then a tagged response held until taken.
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_ready/req_a/req_b/req_op - request side
//               resp_valid/resp_ready/resp_id/resp_data/resp_err - response
//               alu_a/alu_b/alu_op/alu_c - shared ALU interface
// Macro       : ALU_ARB_FASTPATH_EN - arbitrate in the RESP cycle that hands
//               off the response, issuing back-to-back every 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0]  req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_op,
    input  logic [31:0]           alu_c
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [2:0]          r_alu_op;
    logic                r_illegal;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_any;
    logic                w_arb_open;
    logic                w_accept;
    logic [31:0]         w_sel_a;
    logic [31:0]         w_sel_b;
    logic [2:0]          w_sel_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_gnt),
        .idx       (w_gnt_idx),
        .any_grant (w_any)
    );

    // One-hot payload mux driven by the grant vector.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a  = req_a[32*i +: 32];
                w_sel_b  = req_b[32*i +: 32];
                w_sel_op = req_op[3*i +: 3];
            end
        end
    end

    // Next state and request-side handshake. w_arb_open marks the cycles
    // in which a grant may be offered to the requesters.
    always_comb begin
        w_state_nxt = r_state;
        w_arb_open  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_open = 1'b1;
                if (w_any) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
`ifdef ALU_ARB_FASTPATH_EN
                    w_arb_open  = 1'b1;
                    w_state_nxt = w_any ? ST_EXEC : ST_IDLE;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        req_ready = w_arb_open ? w_gnt : '0;
        w_accept  = w_arb_open & w_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_op  <= OP_ADD;
            r_illegal <= 1'b0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a       <= w_sel_a;
                r_b       <= w_sel_b;
                r_id      <= w_gnt_idx;
                r_illegal <= op_illegal(w_sel_op);
                // The op register feeds the ALU directly, so an illegal code
                // is replaced by ADD here; it then also holds after EXEC.
                r_alu_op  <= op_illegal(w_sel_op) ? OP_ADD : w_sel_op;
                r_ptr     <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end
            if (r_state == ST_EXEC) begin
                resp_data <= r_illegal ? '0 : alu_c;
                resp_err  <= r_illegal;
                resp_id   <= r_id;
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_alu_op;

    a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid && !resp_ready |=> resp_valid && $stable(resp_id)
                                      && $stable(resp_data) && $stable(resp_err));

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_hold
            a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
                req_valid[gi] && !req_ready[gi] |=> req_valid[gi]
                    && $stable(req_a[32*gi +: 32]) && $stable(req_b[32*gi +: 32])
                    && $stable(req_op[3*gi +: 3]));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A transaction-level
//               reference model predicts grants, responses and ALU drive;
//               directed scenarios are followed by randomized traffic.
// Macro       : ALU_ARB_FASTPATH_EN - selects the expected issue interval.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N    = 2;
    localparam int IDW  = 2;
`ifdef ALU_ARB_FASTPATH_EN
    localparam int GAP  = 2;
    localparam bit FAST = 1'b1;
`else
    localparam int GAP  = 3;
    localparam bit FAST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a, req_b;
    logic [3*N-1:0]    req_op;
    logic              resp_valid, resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [31:0]       alu_a, alu_b, alu_c;
    logic [2:0]        alu_op;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase 0 = free, 1 = operating on the ALU, 2 = response
    int          m_phase;
    int          m_ptr;
    int          m_id;
    logic [31:0] m_a, m_b, m_data;
    logic [2:0]  m_op;
    logic        m_err;

    logic [N-1:0]   s_req_ready;
    logic           s_resp_valid, s_resp_err;
    logic [IDW-1:0] s_resp_id;
    logic [31:0]    s_resp_data;

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_data(input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (b >= 32) ? 32'd0 : a >> b;
            3'd5: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] op);
        return op == 3'd6 || op == 3'd7;
    endfunction

    // The shared ALU itself lives in the bench.
    assign alu_c = ref_data(alu_op, alu_a, alu_b);

    alu_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round-robin choice among valid requesters, starting at the pointer.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_phase == 0 || (FAST && m_phase == 2 && resp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (r == '0 && req_valid[(m_ptr + k) % N]) r[(m_ptr + k) % N] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_take(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) if (acc[i]) m_id = i;
        m_a    = req_a[32*m_id +: 32];
        m_b    = req_b[32*m_id +: 32];
        m_op   = req_op[3*m_id +: 3];
        m_err  = ref_err(m_op);
        m_data = m_err ? 32'd0 : ref_data(m_op, m_a, m_b);
        m_ptr  = (m_id + 1) % N;
        m_phase = 1;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_id    = 0;
    endtask

    // One clock: check outputs on the falling edge, advance the model on the
    // rising edge, return the accepted-request mask.
    task automatic step(output logic [N-1:0] acc);
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        exp_rdy      = model_ready();
        s_req_ready  = req_ready;
        s_resp_valid = resp_valid;
        s_resp_id    = resp_id;
        s_resp_data  = resp_data;
        s_resp_err   = resp_err;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("resp_valid", resp_valid, m_phase == 2);
        if (m_phase == 2) begin
            check_eq("resp_id", resp_id, m_id);
            check_eq("resp_data", resp_data, m_data);
            check_eq("resp_err", resp_err, m_err);
        end
        if (m_phase == 1) begin
            check_eq("alu_a", alu_a, m_a);
            check_eq("alu_b", alu_b, m_b);
            check_eq("alu_op", alu_op, m_err ? 3'd0 : m_op);
        end
        @(posedge clk);
        acc = exp_rdy;
        if (m_phase == 0) begin
            if (|acc) model_take(acc);
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (resp_ready) begin
            if (|acc) model_take(acc);
            else m_phase = 0;
        end
        #1;
    endtask

    task automatic put_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[3*i +: 3]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drain();
        logic [N-1:0] acc;
        int           k;
        resp_ready = 1'b1;
        k = 0;
        while ((req_valid != '0 || m_phase != 0) && k < 30) begin
            step(acc);
            req_valid &= ~acc;
            k++;
        end
        check_eq("drain_idle", m_phase == 0 && req_valid == '0, 1);
    endtask

    initial begin
        logic [N-1:0] acc;
        int hs, prev, ngr, nresp, k;
        int t[2];
        logic seen;

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        resp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_id", resp_id, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst_alu", {alu_a, alu_b, alu_op}, 0);
        rst_n = 1'b1;

        // Single request: 5 - 3, response two cycles after the handshake
        put_req(0, 32'd5, 32'd3, 3'b001);
        resp_ready = 1'b1;
        step(acc);
        req_valid &= ~acc;
        hs = cyc;
        check_eq("single_grant", acc, 2'b01);
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            step(acc);
            seen = s_resp_valid;
        end
        check_eq("single_seen", seen, 1);
        check_eq("single_latency", cyc - hs, 2);
        check_eq("single_data", s_resp_data, 32'd2);
        check_eq("single_id", s_resp_id, 0);
        check_eq("single_err", s_resp_err, 0);
        drain();

        // Illegal op
        put_req(1, 32'd5, 32'd6, 3'b110);
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            step(acc);
            req_valid &= ~acc;
            seen = s_resp_valid;
        end
        check_eq("ill_seen", seen, 1);
        check_eq("ill_err", s_resp_err, 1);
        check_eq("ill_data", s_resp_data, 0);
        drain();

        // Backpressure: response held, no new grant while stalled
        resp_ready = 1'b0;
        put_req(0, 32'd7, 32'd9, 3'b011);
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            step(acc);
            req_valid &= ~acc;
            seen = s_resp_valid;
        end
        check_eq("bp_seen", seen, 1);
        put_req(1, 32'd100, 32'd1, 3'b000);
        for (k = 0; k < 5; k++) begin
            step(acc);
            req_valid &= ~acc;
            check_eq("bp_hold_data", s_resp_data, 32'hF);
            check_eq("bp_no_grant", s_req_ready, 0);
        end
        drain();

        // Contention: both requesters always valid, grants must alternate
        resp_ready = 1'b1;
        put_req(0, 32'd1, 32'd2, 3'b000);
        put_req(1, 32'h8000_0000, 32'd4, 3'b101);
        prev = -1; ngr = 0; seen = 1'b0;
        for (k = 0; k < 40 && ngr < 6; k++) begin
            step(acc);
            if (s_resp_valid && s_resp_id == 1) begin
                check_eq("sra_data", s_resp_data, 32'hF800_0000);
                seen = 1'b1;
            end
            if (|acc) begin
                if (prev >= 0) check_eq("rr_alternate", acc[1] ? 1 : 0, 1 - prev);
                prev = acc[1] ? 1 : 0;
                ngr++;
            end
        end
        check_eq("contention_grants", ngr, 6);
        check_eq("sra_seen", seen, 1);
        drain();

        // Reset while the ALU is executing
        put_req(0, 32'h1234, 32'h1, 3'b001);
        seen = 1'b0;
        for (k = 0; k < 10 && !seen; k++) begin
            step(acc);
            req_valid &= ~acc;
            seen = |acc;
        end
        check_eq("rstx_accept", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstx_alu", {alu_a, alu_b, alu_op}, 0);
        check_eq("rstx_resp", {resp_valid, resp_id, resp_data, resp_err}, 0);
        check_eq("rstx_req_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (k = 0; k < 4; k++) step(acc);
        put_req(0, 32'd11, 32'd22, 3'b010);
        put_req(1, 32'd33, 32'd44, 3'b011);
        step(acc);
        req_valid &= ~acc;
        check_eq("rr_restart", s_req_ready, 2'b01);
        drain();

        // Issue interval with two queued requests
        resp_ready = 1'b1;
        put_req(0, 32'd3, 32'd4, 3'b000);
        put_req(1, 32'd9, 32'd1, 3'b100);
        nresp = 0;
        for (k = 0; k < 20 && nresp < 2; k++) begin
            step(acc);
            req_valid &= ~acc;
            if (s_resp_valid) begin
                t[nresp] = cyc;
                nresp++;
            end
        end
        check_eq("gap_seen", nresp, 2);
        if (nresp == 2) check_eq("issue_gap", t[1] - t[0], GAP);
        drain();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    put_req(i, $urandom,
                            ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)),
                            3'($urandom_range(0, 7)));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            req_valid &= ~acc;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit combinational ALU (ops ADD/SUB/AND/OR/SRL/SRA, 3-bit op code) between NUM_REQ requesters.
- Uses a round-robin grant and a valid/ready handshake on both the request and response sides.
- Registers the operands, drives the shared ALU for one cycle, captures the result, and returns it tagged with the requester ID.
- Sits between issue logic (e.g. pipeline and address-calc units) and the single ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, packed the same way.
- req_op  in  3*NUM_REQ  ALU op code per requester.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept from the consumer.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  32  ALU result.
- resp_err  out  1  op code was illegal (3'b110 or 3'b111).
- alu_a  out  32  operand A to the shared ALU.
- alu_b  out  32  operand B to the shared ALU.
- alu_op  out  3  op code to the shared ALU.
- alu_c  in  32  result from the shared ALU.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; round-robin pointer = 0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - alu_a=0, alu_b=0, alu_op=3'b000.
  - Any in-flight transaction is dropped silently; no response is produced after reset releases.
- IDLE:
  - Round-robin grant among asserted req_valid bits, starting the search at the pointer.
  - req_ready[g]=1 combinationally for the granted requester g only.
  - On the handshake: latch a, b, op and g; pointer <= (g+1) mod NUM_REQ; go to EXEC.
  - No req_valid asserted: stay in IDLE; pointer unchanged.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op driven from the latched registers.
  - End of cycle: resp_data<=alu_c, resp_err<=0, resp_id<=g; go to RESP.
  - Illegal op: resp_data<=0, resp_err<=1; alu_op is forced to 3'b000 during EXEC.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready=1.
  - On resp_ready=1: go to IDLE.
- req_ready is 0 in every state other than IDLE, and in RESP when the fast path does not apply.
- Latency: handshake in cycle N gives resp_valid in cycle N+2. Throughput is one op per 3 cycles, or per 2 cycles with the optional feature.
- alu_a/alu_b/alu_op hold their last values outside EXEC.
- Protocol rules (checked by assertions):
  - A requester holds req_valid high and its payload stable until accepted.
  - resp_valid never drops without resp_ready.
- Shift semantics belong to the ALU and are not altered here. B>=32 gives SRL=0 and SRA=sign fill.

Optional Feature:
- ALU_ARB_FASTPATH_EN defined:
  - In RESP with resp_ready=1, arbitration runs in the same cycle.
  - If a request is granted, it is accepted and the FSM goes directly to EXEC, skipping IDLE.
  - Back-to-back issue is every 2 cycles.
- Undefined: RESP always returns to IDLE.

Decomposition:
- Package alu_pkg holds:
  - ALU op localparams: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_SRL=100, OP_SRA=101.
  - State encoding: IDLE/EXEC/RESP.
  - MAX_REQ=4.
- One sub-module, rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any_grant.

Test Plan:
- Single request: req0 a=5, b=3, op=001 → resp_valid at N+2, id=0, data=2, err=0.
- Contention: both requesters valid continuously with resp_ready=1 → grants alternate 0,1,0,1; req1 op=101, a=32'h8000_0000, b=4 → data 32'hF800_0000.
- Backpressure: resp_ready=0 for 5 cycles → resp held stable, req_ready stays 0, no new grant.
- Illegal op: op=3'b110 → resp_err=1, data=0, alu_op=000 during EXEC.
- Reset in EXEC: rst_n low → all outputs 0 immediately; no resp_valid after release; pointer restarts at 0.
- With ALU_ARB_FASTPATH_EN: two queued requests → second resp_valid exactly 2 cycles after the first.
